// File: rtl/tlb_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// tlb_port_if / mem_port_if
// ----------------------------------------------------------------------------
// Bus bundles for tlb_mem_arbiter.
//   tlb_port_if : one requester port (instruction or data tlb).
//       req, read, paddr[25:0], write_value[31:0]   requester -> arbiter
//       ack, read_value[31:0], err                  arbiter   -> requester
//   mem_port_if : the shared memory-controller port.
//       req, read, paddr[25:0], write_value[31:0]   arbiter -> memory
//       ack, read_value[31:0]                       memory  -> arbiter
// Revision: 1.0 - initial release
// ============================================================================

interface tlb_port_if;
    logic        req;
    logic        read;
    logic [25:0] paddr;
    logic [31:0] write_value;
    logic        ack;
    logic [31:0] read_value;
    logic        err;

    modport master (output req, read, paddr, write_value,
                    input  ack, read_value, err);
    modport slave  (input  req, read, paddr, write_value,
                    output ack, read_value, err);
endinterface

interface mem_port_if;
    logic        req;
    logic        read;
    logic [25:0] paddr;
    logic [31:0] write_value;
    logic        ack;
    logic [31:0] read_value;

    modport master (output req, read, paddr, write_value,
                    input  ack, read_value);
    modport slave  (input  req, read, paddr, write_value,
                    output ack, read_value);
endinterface

`default_nettype wire

// File: rtl/tlb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tlb_mem_arbiter
// ----------------------------------------------------------------------------
// Shares one memory port between the instruction-tlb and data-tlb ports.
// One transaction at a time: IDLE -> BUSY -> DONE -> IDLE. Ties are broken
// round-robin (FIXED_PRIO=0) or always in favour of the instruction side
// (FIXED_PRIO=1). A watchdog aborts a BUSY phase that sees no mem ack for
// TO_CYCLES+1 cycles and reports it through err and the sticky timeout_flag.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   i_side        instruction-side requester (tlb_port_if.slave)
//   d_side        data-side requester        (tlb_port_if.slave)
//   mem           memory controller port     (mem_port_if.master)
//   timeout_flag  sticky, set by any timeout, cleared only by reset
// All outputs are registered.
// Revision: 1.0 - initial release
// ============================================================================

module tlb_mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int TO_W       = 8,
    parameter int TO_CYCLES  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    tlb_port_if.slave  i_side,
    tlb_port_if.slave  d_side,
    mem_port_if.master mem,
    output logic       timeout_flag
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              grant_d, grant_d_nxt;          // 1 = data side owns the bus
    logic              last_grant_d, last_grant_d_nxt;
    logic [TO_W-1:0]   count, count_nxt;
    logic              mem_req_q, mem_req_nxt;
    logic              mem_read_q, mem_read_nxt;
    logic [25:0]       mem_paddr_q, mem_paddr_nxt;
    logic [31:0]       mem_wdata_q, mem_wdata_nxt;
    logic              i_ack_q, i_ack_nxt, i_err_q, i_err_nxt;
    logic [31:0]       i_rdata_q, i_rdata_nxt;
    logic              d_ack_q, d_ack_nxt, d_err_q, d_err_nxt;
    logic [31:0]       d_rdata_q, d_rdata_nxt;
    logic              timeout_q, timeout_nxt;

    logic              win_d;
    logic              fin;
    logic              fin_err;
    logic [31:0]       fin_rdata;

    // Data side wins when it is the only requester, or on a tie when
    // round-robin is selected and the instruction side was served last.
    assign win_d = d_side.req & ~(i_side.req & (FIXED_PRIO | last_grant_d));

    always_comb begin
        state_nxt        = state;
        grant_d_nxt      = grant_d;
        last_grant_d_nxt = last_grant_d;
        count_nxt        = count;
        mem_req_nxt      = mem_req_q;
        mem_read_nxt     = mem_read_q;
        mem_paddr_nxt    = mem_paddr_q;
        mem_wdata_nxt    = mem_wdata_q;
        timeout_nxt      = timeout_q;
        // Responses are single-cycle pulses; read data is zero outside them.
        i_ack_nxt        = 1'b0;
        i_err_nxt        = 1'b0;
        i_rdata_nxt      = 32'd0;
        d_ack_nxt        = 1'b0;
        d_err_nxt        = 1'b0;
        d_rdata_nxt      = 32'd0;
        fin              = 1'b0;
        fin_err          = 1'b0;
        fin_rdata        = 32'd0;

        case (state)
            ST_IDLE: begin
                if (i_side.req | d_side.req) begin
                    state_nxt     = ST_BUSY;
                    grant_d_nxt   = win_d;
                    count_nxt     = '0;
                    mem_req_nxt   = 1'b1;
                    mem_read_nxt  = win_d ? d_side.read        : i_side.read;
                    mem_paddr_nxt = win_d ? d_side.paddr       : i_side.paddr;
                    mem_wdata_nxt = win_d ? d_side.write_value : i_side.write_value;
                end
            end
            ST_BUSY: begin
                // A real ack wins over a watchdog expiry in the same cycle.
                if (mem.ack) begin
                    fin       = 1'b1;
                    fin_rdata = mem_read_q ? mem.read_value : 32'd0;
                end else if (count == TO_LIMIT) begin
                    fin         = 1'b1;
                    fin_err     = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    count_nxt = count + TO_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt        = ST_IDLE;
                last_grant_d_nxt = grant_d;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (fin) begin
            state_nxt   = ST_DONE;
            mem_req_nxt = 1'b0;
            if (grant_d) begin
                d_ack_nxt   = 1'b1;
                d_err_nxt   = fin_err;
                d_rdata_nxt = fin_rdata;
            end else begin
                i_ack_nxt   = 1'b1;
                i_err_nxt   = fin_err;
                i_rdata_nxt = fin_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            grant_d      <= 1'b0;
            last_grant_d <= 1'b1;
            count        <= '0;
            mem_req_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_paddr_q  <= 26'd0;
            mem_wdata_q  <= 32'd0;
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= 32'd0;
            timeout_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant_d      <= grant_d_nxt;
            last_grant_d <= last_grant_d_nxt;
            count        <= count_nxt;
            mem_req_q    <= mem_req_nxt;
            mem_read_q   <= mem_read_nxt;
            mem_paddr_q  <= mem_paddr_nxt;
            mem_wdata_q  <= mem_wdata_nxt;
            i_ack_q      <= i_ack_nxt;
            i_err_q      <= i_err_nxt;
            i_rdata_q    <= i_rdata_nxt;
            d_ack_q      <= d_ack_nxt;
            d_err_q      <= d_err_nxt;
            d_rdata_q    <= d_rdata_nxt;
            timeout_q    <= timeout_nxt;
        end
    end

    assign mem.req            = mem_req_q;
    assign mem.read           = mem_read_q;
    assign mem.paddr          = mem_paddr_q;
    assign mem.write_value    = mem_wdata_q;
    assign i_side.ack         = i_ack_q;
    assign i_side.err         = i_err_q;
    assign i_side.read_value  = i_rdata_q;
    assign d_side.ack         = d_ack_q;
    assign d_side.err         = d_err_q;
    assign d_side.read_value  = d_rdata_q;
    assign timeout_flag       = timeout_q;

endmodule

`default_nettype wire
